// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO in front of a runtime-configurable
// serial framer (5-8 data bits, optional parity, 1/2 stop bits, CTS, break).
module uart_tx_buffered #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    data_bit_num,
  input  logic                          stop_bit_num,
  input  logic                          parity_en,
  input  logic                          parity_type,
  input  logic                          cts_n,
  input  logic                          send_break,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK, S_BRK_MARK
  } state_e;

  // ---------------- transmit FIFO ----------------
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        full, empty, push, pop;
  logic [7:0]  head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign wr_ready   = !full;
  assign push       = wr_valid && !full;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  // FIFO storage write port.
  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // FIFO pointer registers.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // ---------------- framer ----------------
  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d, last_idx_q, last_idx_d;
  logic             par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
  logic             tx_q, tx_d, tx_done_q, tx_done_d;

  logic [DIV_W-1:0] div_eff;
  logic [3:0]       nbits_in;
  logic [7:0]       act_mask;
  logic             bit_end;

  assign div_eff  = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
  assign nbits_in = 4'd5 + {2'b00, data_bit_num};
  assign act_mask = ~(8'hFF << nbits_in);
  assign bit_end  = (cnt_q == DIV_W'(1));

  // Next-state, bit timer, frame latching and next tx level.
  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    last_idx_d = last_idx_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    tx_done_d  = 1'b0;
    pop        = 1'b0;
    tx_d       = 1'b1;
    if (state_q != S_IDLE) cnt_d = bit_end ? div_q : cnt_q - DIV_W'(1);
    unique case (state_q)
      S_IDLE: begin
        if (send_break) begin
          state_d = S_BREAK;
          div_d   = div_eff;
          cnt_d   = div_eff;
        end else if (!empty && !cts_n) begin
          pop        = 1'b1;
          state_d    = S_START;
          div_d      = div_eff;
          cnt_d      = div_eff;
          shift_d    = head;
          last_idx_d = 3'd4 + {1'b0, data_bit_num};
          par_en_d   = parity_en;
          par_bit_d  = (^(head & act_mask)) ^ ~parity_type;
          stop2_d    = stop_bit_num;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          if (bit_idx_q == last_idx_q) begin
            state_d = par_en_q ? S_PARITY : S_STOP1;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        tx_d = par_bit_q;
        if (bit_end) state_d = S_STOP1;
      end
      S_STOP1: begin
        if (bit_end) begin
          state_d   = stop2_q ? S_STOP2 : S_IDLE;
          tx_done_d = !stop2_q;
        end
      end
      S_STOP2: begin
        if (bit_end) begin
          state_d   = S_IDLE;
          tx_done_d = 1'b1;
        end
      end
      S_BREAK: begin
        tx_d = 1'b0;
        // Timer parks at 1 while the break is still requested.
        if (bit_end && send_break) cnt_d = cnt_q;
        else if (bit_end)          state_d = S_BRK_MARK;
      end
      S_BRK_MARK: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Framer registers; tx is registered so it carries no input-to-pin path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= DIV_W'(2);
      shift_q    <= '0;
      bit_idx_q  <= '0;
      last_idx_q <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      last_idx_q <= last_idx_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_done = tx_done_q;
  assign busy    = (state_q != S_IDLE);

endmodule
